// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and per-stage control-bundle layout constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } pipe_state_t;

    localparam int unsigned IFID_CTRL_W  = 4;
    localparam int unsigned IDEX_CTRL_W  = 10;
    localparam int unsigned EXMEM_CTRL_W = 10;
    localparam int unsigned MEMWB_CTRL_W = 4;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMWRITE = 1;
    localparam int unsigned CTRL_JUMP     = 2;
    localparam int unsigned CTRL_BRANCH   = 3;

    // Only bits with architectural side effects need clearing in a bubble.
    localparam logic [IDEX_CTRL_W-1:0] IDEX_KILL_MASK = IDEX_CTRL_W'(
        (1 << CTRL_REGWRITE) | (1 << CTRL_MEMWRITE) | (1 << CTRL_JUMP) | (1 << CTRL_BRANCH));

    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_KILL_MASK = EXMEM_CTRL_W'(
        (1 << CTRL_REGWRITE) | (1 << CTRL_MEMWRITE));

endpackage

// File: rtl/pipe_stage_slot.sv
// One {ctrl,data} holding register: load has priority over the masked clear of ctrl.
module pipe_stage_slot #(
    parameter int unsigned       CTRL_W    = 10,
    parameter int unsigned       DATA_W    = 160,
    parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else if (load) begin
            ctrl_q <= load_ctrl;
            data_q <= load_data;
        end else if (clear) begin
            // Data is left alone; only the side-effect bits must become inert.
            ctrl_q <= ctrl_q & ~KILL_MASK;
        end
    end

    assign ctrl = ctrl_q;
    assign data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready, stall, flush and an optional skid entry.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W    = 10,
    parameter int unsigned       DATA_W    = 160,
    parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
    parameter bit                SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_t state_q, state_d;

    logic              acc_in, acc_out;
    logic              main_load, main_clear, skid_load, load_from_skid;
    logic [CTRL_W-1:0] skid_ctrl, main_in_ctrl;
    logic [DATA_W-1:0] skid_data, main_in_data;

    // With a skid entry, ready depends only on registered state.
    always_comb begin
        if (SKID) begin
            in_ready = ~stall & (state_q != FULL2);
        end else begin
            in_ready = ~stall & ((state_q == EMPTY) | out_ready);
        end
    end

    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign acc_in    = in_valid & in_ready & ~stall & ~flush;
    assign acc_out   = out_valid & out_ready & ~stall & ~flush;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        skid_load      = 1'b0;
        load_from_skid = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc_in) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (acc_in && acc_out) begin
                        main_load = 1'b1;
                    end else if (acc_out) begin
                        main_clear = 1'b1;
                        state_d    = EMPTY;
                    end else if (acc_in && SKID) begin
                        skid_load = 1'b1;
                        state_d   = FULL2;
                    end
                end
                FULL2: begin
                    if (acc_out) begin
                        main_load      = 1'b1;
                        load_from_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_in_ctrl = load_from_skid ? skid_ctrl : in_ctrl;
    assign main_in_data = load_from_skid ? skid_data : in_data;

    pipe_stage_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .KILL_MASK(KILL_MASK)
    ) u_main (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (main_load),
        .clear    (main_clear),
        .load_ctrl(main_in_ctrl),
        .load_data(main_in_data),
        .ctrl     (out_ctrl),
        .data     (out_data)
    );

    if (SKID) begin : g_skid
        pipe_stage_slot #(
            .CTRL_W   (CTRL_W),
            .DATA_W   (DATA_W),
            .KILL_MASK(KILL_MASK)
        ) u_skid (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (skid_load),
            .clear    (1'b0),
            .load_ctrl(in_ctrl),
            .load_data(in_data),
            .ctrl     (skid_ctrl),
            .data     (skid_data)
        );
    end else begin : g_no_skid
        logic unused_skid_load;
        assign unused_skid_load = skid_load;
        assign skid_ctrl        = '0;
        assign skid_data        = '0;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: one SKID=1 stage with a partial kill mask and one SKID=0 stage.
module tb_pipe_stage_reg;
    localparam int unsigned CW = 10;
    localparam int unsigned DW = 160;
    localparam logic [CW-1:0] MASK1 = pipe_pkg::IDEX_KILL_MASK;
    localparam logic [CW-1:0] MASK0 = {CW{1'b1}};

    logic clk = 1'b0;
    logic rst_n, stall, flush;
    logic in_valid, out_ready, in_valid0, out_ready0;
    logic [CW-1:0] in_ctrl, in_ctrl0;
    logic [DW-1:0] in_data, in_data0;

    logic s1_in_ready, s1_out_valid, s0_in_ready, s0_out_valid;
    logic [CW-1:0] s1_out_ctrl, s0_out_ctrl;
    logic [DW-1:0] s1_out_data, s0_out_data;
    logic [1:0] s1_occ, s0_occ;

    logic [CW+DW-1:0] q1[$];
    logic [CW+DW-1:0] q0[$];
    int checks = 0;
    int failures = 0;
    bit acc1, acc0;
    int n_out0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .KILL_MASK(MASK1), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(s1_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s1_out_valid), .out_ready(out_ready), .out_ctrl(s1_out_ctrl),
        .out_data(s1_out_data), .occupancy(s1_occ)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .KILL_MASK(MASK0), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid0), .in_ready(s0_in_ready), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(s0_out_valid), .out_ready(out_ready0), .out_ctrl(s0_out_ctrl),
        .out_data(s0_out_data), .occupancy(s0_occ)
    );

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks both stages against their models, then advances the models to the next edge.
    task automatic step();
        logic rdy1, rdy0, mv1, mv0;
        #1;
        mv1  = (q1.size() != 0);
        rdy1 = !stall && (q1.size() != 2);
        check_eq("s1_in_ready", s1_in_ready, rdy1);
        check_eq("s1_out_valid", s1_out_valid, mv1);
        check_eq("s1_occupancy", s1_occ, q1.size());
        if (mv1) begin
            check_eq("s1_out_ctrl", s1_out_ctrl, q1[0][CW+DW-1:DW]);
            check_eq("s1_out_data", s1_out_data, q1[0][DW-1:0]);
        end else begin
            check_eq("s1_bubble_ctrl", s1_out_ctrl & MASK1, 0);
        end
        mv0  = (q0.size() != 0);
        rdy0 = !stall && (q0.size() == 0 || out_ready0);
        check_eq("s0_in_ready", s0_in_ready, rdy0);
        check_eq("s0_out_valid", s0_out_valid, mv0);
        check_eq("s0_occupancy", s0_occ, q0.size());
        if (mv0) begin
            check_eq("s0_out_data", s0_out_data, q0[0][DW-1:0]);
        end else begin
            check_eq("s0_bubble_ctrl", s0_out_ctrl & MASK0, 0);
        end
        acc1 = 1'b0;
        acc0 = 1'b0;
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (mv1 && out_ready && !stall) void'(q1.pop_front());
            if (in_valid && rdy1) begin
                q1.push_back({in_ctrl, in_data});
                acc1 = 1'b1;
            end
            if (mv0 && out_ready0 && !stall) begin
                void'(q0.pop_front());
                n_out0++;
            end
            if (in_valid0 && rdy0) begin
                q0.push_back({in_ctrl0, in_data0});
                acc0 = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 0; in_valid0 = 0; out_ready = 1; out_ready0 = 1; stall = 0; flush = 0;
        for (int i = 0; i < 10 && (q1.size() != 0 || q0.size() != 0); i++) step();
        step();
        check_eq("drain_q1", q1.size(), 0);
        check_eq("drain_q0", q0.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int k;
        logic [DW-1:0] bp[3];
        rst_n = 0; stall = 0; flush = 0; n_out0 = 0;
        in_valid = 0; in_ctrl = '0; in_data = '0; out_ready = 0;
        in_valid0 = 0; in_ctrl0 = '0; in_data0 = '0; out_ready0 = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", s1_out_valid, 0);
        check_eq("rst_out_ctrl", s1_out_ctrl, 0);
        check_eq("rst_out_data", s1_out_data, 0);
        check_eq("rst_occupancy", s1_occ, 0);
        rst_n = 1;
        step();

        // Streaming: 8 back-to-back beats with 1-cycle latency.
        out_ready = 1; in_valid = 1; k = 1;
        for (int i = 0; i < 40 && k <= 8; i++) begin
            in_ctrl = CW'(k); in_data = DW'(k);
            step();
            if (acc1) k++;
        end
        check_eq("stream_sent", k, 9);
        drain();

        // Backpressure into the skid entry.
        bp[0] = 'hA; bp[1] = 'hB; bp[2] = 'hC;
        out_ready = 0; in_valid = 1; in_ctrl = 10'h005; k = 0;
        for (int i = 0; i < 3; i++) begin
            in_data = bp[k];
            step();
            if (acc1) k++;
        end
        check_eq("bp_accepted", k, 2);
        out_ready = 1;
        for (int i = 0; i < 10 && k < 3; i++) begin
            in_data = bp[k];
            step();
            if (acc1) k++;
        end
        drain();

        // Flush while FULL2 with an incoming beat.
        out_ready = 0; in_valid = 1; in_ctrl = 10'h3FF;
        in_data = 'h11; step();
        in_data = 'h22; step();
        in_data = 'h33; flush = 1; step();
        flush = 0; in_valid = 0; step();
        check_eq("flush_ctrl_kept", s1_out_ctrl, 10'h3FF & ~MASK1);
        check_eq("flush_data_held", s1_out_data, 'h11);
        out_ready = 1; repeat (3) step();

        // Stall+flush together, then stall alone.
        out_ready = 0; in_valid = 1; in_ctrl = 10'h00F; in_data = 'h55; step();
        in_data = 'h66; stall = 1; flush = 1; step();
        stall = 0; flush = 0; in_valid = 0; step();
        in_valid = 1; in_data = 'h77; step();
        in_data = 'h88; stall = 1; out_ready = 1; repeat (3) step();
        check_eq("stall_frozen_data", s1_out_data, 'h77);
        stall = 0; step();
        drain();

        // SKID=0 stage with toggling out_ready under continuous input.
        in_valid0 = 1; in_ctrl0 = 10'h3FF; k = 0; n_out0 = 0;
        for (int i = 0; i < 12; i++) begin
            out_ready0 = (i % 2 == 0);
            in_data0 = DW'(k + 'h100);
            step();
            if (acc0) k++;
        end
        drain();
        check_eq("s0_no_loss", n_out0, k);

        // Asynchronous reset while holding two entries.
        out_ready = 0; in_valid = 1; in_ctrl = 10'h3FF;
        in_data = 'h91; step();
        in_data = 'h92; step();
        in_valid = 0;
        #3 rst_n = 0;
        #1;
        check_eq("arst_out_valid", s1_out_valid, 0);
        check_eq("arst_out_ctrl", s1_out_ctrl, 0);
        check_eq("arst_occupancy", s1_occ, 0);
        q1.delete(); q0.delete();
        @(negedge clk);
        rst_n = 1;
        step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
